serial_pattern_gen: RTL and testbench

SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

---
 rtl/serial_pkg.sv | 13 +
 rtl/pattern_shreg.sv | 52 +++++
 rtl/serial_pattern_gen.sv | 114 +++++++++++
 tb/tb_serial_pattern_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detector.
package serial_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/pattern_shreg.sv
// Pattern shift register with shadow copy so a looped pattern reloads with no gap bit.
module pattern_shreg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_o,
    input  logic             reset,
    input  logic             load,
    input  logic             reload,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] pattern,
    output logic             msb
);

    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;

    // Per-bit next value: fresh load wins, then reload from shadow, then shift left with zero fill.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shift_next[gi] = load     ? pattern[gi]    :
                                        reload   ? shadow_reg[gi] :
                                        shift_en ? 1'b0           :
                                                   shift_reg[gi];
            end else begin : g_upper
                assign shift_next[gi] = load     ? pattern[gi]      :
                                        reload   ? shadow_reg[gi]   :
                                        shift_en ? shift_reg[gi-1]  :
                                                   shift_reg[gi];
            end
        end
    endgenerate

    // Shadow captures the pattern only at launch; shift register follows shift_next.
    always_ff @(posedge clk_o or posedge reset) begin
        if (reset) begin
            shadow_reg <= '0;
            shift_reg  <= '0;
        end else begin
            if (load) begin
                shadow_reg <= pattern;
            end
            shift_reg <= shift_next;
        end
    end

    assign msb = shift_reg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends the top len bits of a latched pattern MSB first,
// optionally looping, with registered status outputs.
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_o,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             loop,
    output logic             sdata,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_idx
);

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] len_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CNT_W-1:0] eff_len;
    logic             launch;
    logic             last_bit;
    logic             reload;
    logic             shreg_msb;

    // Zero or oversize lengths mean "send the whole pattern".
    assign eff_len  = ((len == '0) || (len > WIDTH_CNT)) ? WIDTH_CNT : len;
    assign launch   = (state_reg == ST_IDLE) && start;
    assign last_bit = (state_reg == ST_SHIFT) && (cnt_reg == ONE_CNT);
    assign reload   = last_bit && loop;

    pattern_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk_o    (clk_o),
        .reset    (reset),
        .load     (launch),
        .reload   (reload),
        .shift_en (state_reg == ST_SHIFT),
        .pattern  (pattern),
        .msb      (shreg_msb)
    );

    // Control FSM with bit counter; status flags are registered alongside the state.
    always_ff @(posedge clk_o or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= ST_SHIFT;
                        cnt_reg   <= eff_len;
                        len_reg   <= eff_len;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg == ONE_CNT) begin
                        if (loop) begin
                            // Pattern boundary: restart count, shift register reloads in step.
                            cnt_reg <= len_reg;
                        end else begin
                            state_reg <= ST_DONE;
                            cnt_reg   <= '0;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - ONE_CNT;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sdata   = valid_reg & shreg_msb;
    assign valid   = valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bit_idx = cnt_reg;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen with hand-computed expected bit streams.
module tb_serial_pattern_gen;

    logic        clk_o;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        loop;
    logic        sdata;
    logic        valid;
    logic        busy;
    logic        done;
    logic [4:0]  bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    serial_pattern_gen #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk_o   (clk_o),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .loop    (loop),
        .sdata   (sdata),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    initial clk_o = 1'b0;
    always #5 clk_o = ~clk_o;

    task automatic tick();
        @(posedge clk_o);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_sdata"}, 32'(sdata), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_idx"},   32'(bit_idx), 32'd0);
    endtask

    // Checks nbits contiguous bits of p (period n), then the DONE cycle and the IDLE cycle.
    task automatic send_expect(input string tag, input logic [15:0] p, input int n, input int nbits,
                               input int drop_loop_at, input int disturb_at);
        int pos;
        for (int k = 0; k < nbits; k++) begin
            pos = k % n;
            chk({tag, "_sdata"}, 32'(sdata), 32'(p[15-pos]));
            chk({tag, "_valid"}, 32'(valid), 32'd1);
            chk({tag, "_busy"},  32'(busy),  32'd1);
            chk({tag, "_idx"},   32'(bit_idx), 32'(n - pos));
            chk({tag, "_done"},  32'(done),  32'd0);
            $display("%s bit %0d: sdata=%0b idx=%0d", tag, k, sdata, bit_idx);
            if (k == drop_loop_at) loop = 1'b0;
            if (k == disturb_at) begin
                start   = 1'b1;
                pattern = 16'hFFFF;
                len     = 5'd3;
            end
            if (disturb_at >= 0 && k == disturb_at + 1) start = 1'b0;
            tick();
        end
        chk({tag, "_done_pulse"}, 32'(done),  32'd1);
        chk({tag, "_done_valid"}, 32'(valid), 32'd0);
        chk({tag, "_done_sdata"}, 32'(sdata), 32'd0);
        chk({tag, "_done_busy"},  32'(busy),  32'd1);
        tick();
        chk_quiet({tag, "_idle"});
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = 16'h0000;
        len     = 5'd0;
        loop    = 1'b0;
        #2;
        chk_quiet("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_quiet("post_reset");
        $display("reset released");

        // Six-bit pattern, single shot: 1,0,1,0,1,1 then done.
        pattern = 16'hAC00; len = 5'd6; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pattern = 16'h0000;
        send_expect("single", 16'hAC00, 6, 6, -1, -1);

        // Looped three times, loop dropped mid third pattern: 18 contiguous bits.
        pattern = 16'hAC00; len = 5'd6; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        send_expect("loop3", 16'hAC00, 6, 18, 13, -1);

        // len=0 and len=20 both mean full width.
        pattern = 16'h8001; len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        send_expect("len0", 16'h8001, 16, 16, -1, -1);
        pattern = 16'h8001; len = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        send_expect("len20", 16'h8001, 16, 16, -1, -1);

        // Restart with a different pattern while busy is ignored.
        pattern = 16'hAC00; len = 5'd6; start = 1'b1;
        tick();
        start = 1'b0;
        send_expect("busy_start", 16'hAC00, 6, 6, -1, 2);
        start = 1'b0; pattern = 16'h0000; len = 5'd0;

        // Reset during the third bit aborts asynchronously with no done.
        pattern = 16'hAC00; len = 5'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_bit3_sdata", 32'(sdata), 32'd1);
        chk("abort_bit3_idx",   32'(bit_idx), 32'd4);
        #1 reset = 1'b1;
        #1;
        chk_quiet("abort_async");
        $display("reset asserted mid-run");
        tick();
        reset = 1'b0;
        tick();
        chk_quiet("abort_wait1");
        tick();
        chk_quiet("abort_wait2");
        start = 1'b1;
        tick();
        start = 1'b0;
        send_expect("after_abort", 16'hAC00, 6, 6, -1, -1);

        // Start held high: 1,1,DONE,IDLE repeating every four cycles.
        pattern = 16'hC000; len = 5'd2; start = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            chk("hold_b0_sdata", 32'(sdata), 32'd1);
            chk("hold_b0_idx",   32'(bit_idx), 32'd2);
            tick();
            chk("hold_b1_sdata", 32'(sdata), 32'd1);
            chk("hold_b1_idx",   32'(bit_idx), 32'd1);
            tick();
            chk("hold_done",       32'(done),  32'd1);
            chk("hold_done_valid", 32'(valid), 32'd0);
            tick();
            chk("hold_idle_done",  32'(done),  32'd0);
            chk("hold_idle_valid", 32'(valid), 32'd0);
            chk("hold_idle_busy",  32'(busy),  32'd0);
            $display("held start run %0d complete", r);
            tick();
        end
        start = 1'b0;
        tick();
        tick();
        tick();
        chk_quiet("hold_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
